vram_fetch_arbiter: RTL and testbench

//  Shares the single-port video RAM between the CPU and the scanline fetcher.

---
 rtl/vram_fetch_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_vram_fetch_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_fetch_arbiter.sv
// Single-port VRAM arbiter: copies the next visible scanline into a ping-pong
// line buffer at the start of h-blank and serves CPU accesses in the gaps.
module vram_fetch_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 16,
    parameter int WORDS    = 40,
    parameter int STRIDE   = 40,
    parameter int FB_BASE  = 0,
    parameter int LB_AW    = 7,
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        pixel_row,
    input  logic [9:0]        pixel_column,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              lb_we,
    output logic [LB_AW-1:0]  lb_addr,
    output logic [DATA_W-1:0] lb_wdata,
    output logic              fetch_busy,
    output logic              overrun,
    input  logic              overrun_clr
);
    localparam int IW = LB_AW - 1;
    localparam int CW = LB_AW + 1;
    localparam logic [CW-1:0]     LAST     = CW'(WORDS + 1);
    localparam logic [CW-1:0]     NWORDS   = CW'(WORDS);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(FB_BASE);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        CPU_ISSUE,
        CPU_ACK
    } state_t;

    state_t state, state_nx;

    logic [9:0]        next_row;
    logic              trigger;
    logic [ADDR_W-1:0] line_addr;
    logic [CW-1:0]     fcnt, fcnt_nx, fcnt_inc;
    logic              pending, pending_nx;
    logic              bank, bank_nx;
    logic              go_fetch, go_cpu;
    logic              en_nx, we_nx, busy_nx, ack_nx;
    logic              ack_rd, ack_rd_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [DATA_W-1:0] wdata_nx;
    logic              rd_pend;
    logic [IW-1:0]     rd_idx;
    logic [DATA_W-1:0] rdata_hold;

    assign next_row  = (pixel_row == 10'(V_TOTAL - 1)) ? 10'd0 : pixel_row + 10'd1;
    assign trigger   = (pixel_column == 10'(H_ACTIVE)) && (next_row < 10'(V_ACTIVE));
    assign line_addr = BASE_A + ADDR_W'(next_row) * STRIDE_A;
    assign fcnt_inc  = fcnt + CW'(1);

    // Read data arrives in the ack cycle itself, so it bypasses the hold register.
    assign cpu_rdata = ack_rd ? mem_rdata : rdata_hold;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        fcnt_nx    = fcnt;
        bank_nx    = bank;
        pending_nx = pending;
        en_nx      = 1'b0;
        we_nx      = 1'b0;
        addr_nx    = mem_addr;
        wdata_nx   = mem_wdata;
        busy_nx    = 1'b0;
        ack_nx     = 1'b0;
        ack_rd_nx  = 1'b0;
        go_fetch   = 1'b0;
        go_cpu     = 1'b0;

        unique case (state)
            IDLE: begin
                go_fetch = trigger || pending;
                go_cpu   = !(trigger || pending) && cpu_req;
            end
            FETCH: begin
                // The last busy cycle doubles as the idle decision slot for a waiting CPU.
                if (fcnt == LAST) begin
                    state_nx = IDLE;
                    go_cpu   = cpu_req;
                end else begin
                    busy_nx = 1'b1;
                    fcnt_nx = fcnt_inc;
                    if (fcnt_inc < NWORDS) begin
                        en_nx   = 1'b1;
                        addr_nx = mem_addr + ADDR_W'(1);
                    end
                end
            end
            CPU_ISSUE: begin
                state_nx  = CPU_ACK;
                ack_nx    = 1'b1;
                ack_rd_nx = !mem_we;
            end
            CPU_ACK: begin
                state_nx = IDLE;
            end
        endcase

        if (go_fetch) begin
            state_nx   = FETCH;
            fcnt_nx    = '0;
            bank_nx    = next_row[0];
            en_nx      = 1'b1;
            addr_nx    = line_addr;
            busy_nx    = 1'b1;
            pending_nx = 1'b0;
        end
        if (go_cpu) begin
            state_nx = CPU_ISSUE;
            en_nx    = 1'b1;
            we_nx    = cpu_we;
            addr_nx  = cpu_addr;
            wdata_nx = cpu_wdata;
        end
        if (trigger && (state == CPU_ISSUE || state == CPU_ACK)) begin
            pending_nx = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fcnt       <= '0;
            bank       <= 1'b0;
            pending    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            fetch_busy <= 1'b0;
            cpu_ack    <= 1'b0;
            ack_rd     <= 1'b0;
            rd_pend    <= 1'b0;
            rd_idx     <= '0;
            lb_we      <= 1'b0;
            lb_addr    <= '0;
            lb_wdata   <= '0;
            rdata_hold <= '0;
            overrun    <= 1'b0;
        end else begin
            fcnt       <= fcnt_nx;
            bank       <= bank_nx;
            pending    <= pending_nx;
            mem_en     <= en_nx;
            mem_we     <= we_nx;
            mem_addr   <= addr_nx;
            mem_wdata  <= wdata_nx;
            fetch_busy <= busy_nx;
            cpu_ack    <= ack_nx;
            ack_rd     <= ack_rd_nx;
            rd_pend    <= (state == FETCH) && mem_en;
            rd_idx     <= fcnt[IW-1:0];
            lb_we      <= rd_pend;
            if (rd_pend) begin
                lb_addr  <= {bank, rd_idx};
                lb_wdata <= mem_rdata;
            end
            if (ack_rd) begin
                rdata_hold <= mem_rdata;
            end
            if (trigger && fetch_busy) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// Directed + randomized bench for vram_fetch_arbiter with a VRAM model
// and a line/CPU reference built from the row/address arithmetic.
module tb_vram_fetch_arbiter;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 16;
    localparam int WORDS  = 40;
    localparam int STRIDE = 40;
    localparam int FB_BASE = 0;
    localparam int LB_AW  = 7;

    logic              clk = 1'b0;
    logic              reset;
    logic [9:0]        pixel_row, pixel_column;
    logic              cpu_req, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              mem_en, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              lb_we;
    logic [LB_AW-1:0]  lb_addr;
    logic [DATA_W-1:0] lb_wdata;
    logic              fetch_busy, overrun, overrun_clr;

    logic [DATA_W-1:0] vram   [0:(1<<ADDR_W)-1];
    logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];

    int errors = 0;
    int checks = 0;
    logic [DATA_W-1:0] last_rd;
    logic ovr_exp;

    vram_fetch_arbiter dut (
        .clk(clk), .reset(reset),
        .pixel_row(pixel_row), .pixel_column(pixel_column),
        .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .lb_we(lb_we), .lb_addr(lb_addr), .lb_wdata(lb_wdata),
        .fetch_busy(fetch_busy), .overrun(overrun),
        .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) vram[mem_addr] <= mem_wdata;
            else mem_rdata <= vram[mem_addr];
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_mem_en"}, 32'(mem_en), 0);
        chk({tag, "_lb_we"}, 32'(lb_we), 0);
        chk({tag, "_busy"}, 32'(fetch_busy), 0);
        chk({tag, "_ack"}, 32'(cpu_ack), 0);
    endtask

    task automatic run_fetch(input int row, input int ovr_at, input int clr_at, input int rst_at);
        int nr, busy_n, i;
        bit exp_fetch, exp_busy, exp_en, exp_lbwe;
        logic [ADDR_W-1:0] a;
        nr = (row == 524) ? 0 : row + 1;
        exp_fetch = (nr < 480);
        busy_n = 0;
        pixel_row = 10'(row);
        pixel_column = 10'd640;
        overrun_clr = 1'b0;
        for (int k = 1; k <= WORDS + 4; k++) begin
            @(negedge clk);
            pixel_column = (k == ovr_at) ? 10'd640 : 10'd641;
            overrun_clr = (k == clr_at);
            exp_busy = exp_fetch && k <= WORDS + 2;
            exp_en   = exp_fetch && k <= WORDS;
            exp_lbwe = exp_fetch && k >= 3 && k <= WORDS + 2;
            if (fetch_busy) busy_n++;
            chk($sformatf("busy_r%0d_k%0d", row, k), 32'(fetch_busy), 32'(exp_busy));
            chk($sformatf("mem_en_r%0d_k%0d", row, k), 32'(mem_en), 32'(exp_en));
            chk($sformatf("overrun_r%0d_k%0d", row, k), 32'(overrun), 32'(ovr_exp));
            if (exp_en) begin
                i = k - 1;
                a = ADDR_W'(FB_BASE + nr * STRIDE + i);
                chk($sformatf("mem_we_r%0d_k%0d", row, k), 32'(mem_we), 0);
                chk($sformatf("mem_addr_r%0d_k%0d", row, k), 32'(mem_addr), 32'(a));
            end
            chk($sformatf("lb_we_r%0d_k%0d", row, k), 32'(lb_we), 32'(exp_lbwe));
            if (exp_lbwe) begin
                i = k - 3;
                a = ADDR_W'(FB_BASE + nr * STRIDE + i);
                chk($sformatf("lb_addr_r%0d_k%0d", row, k), 32'(lb_addr), (32'(nr & 1) << 6) | 32'(i));
                chk($sformatf("lb_wdata_r%0d_k%0d", row, k), 32'(lb_wdata), 32'(shadow[a]));
            end
            if (k == rst_at) begin
                reset = 1'b1;
                #1;
                chk("rst_mid_lb_we", 32'(lb_we), 0);
                chk("rst_mid_mem_en", 32'(mem_en), 0);
                chk("rst_mid_busy", 32'(fetch_busy), 0);
                ovr_exp = 1'b0;
                last_rd = '0;
                @(negedge clk);
                reset = 1'b0;
                pixel_column = 10'd641;
                overrun_clr = 1'b0;
                break;
            end
            if (k == ovr_at && exp_busy) ovr_exp = 1'b1;
            else if (k == clr_at) ovr_exp = 1'b0;
        end
        overrun_clr = 1'b0;
        if (rst_at == 0) chk($sformatf("busy_len_r%0d", row), 32'(busy_n), exp_fetch ? WORDS + 2 : 0);
    endtask

    task automatic cpu_access(input logic we, input logic [ADDR_W-1:0] addr,
                              input logic [DATA_W-1:0] wd, input int trig_row);
        int lat, reads;
        bit got;
        logic [DATA_W-1:0] exp_rd;
        lat = (trig_row >= 0) ? WORDS + 4 : 2;
        reads = 0;
        got = 0;
        exp_rd = we ? last_rd : shadow[addr];
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = addr;
        cpu_wdata = wd;
        if (trig_row >= 0) begin
            pixel_row = 10'(trig_row);
            pixel_column = 10'd640;
        end
        for (int k = 1; k <= lat + 5 && !got; k++) begin
            @(negedge clk);
            pixel_column = 10'd641;
            if (mem_en && k < lat - 1) reads++;
            if (k == lat - 1) begin
                chk("cpu_mem_en", 32'(mem_en), 1);
                chk("cpu_mem_we", 32'(mem_we), 32'(we));
                chk("cpu_mem_addr", 32'(mem_addr), 32'(addr));
                if (we) chk("cpu_mem_wdata", 32'(mem_wdata), 32'(wd));
            end
            if (cpu_ack) begin
                got = 1;
                chk("cpu_ack_latency", 32'(k), 32'(lat));
                chk("cpu_rdata_ack", 32'(cpu_rdata), 32'(exp_rd));
                cpu_req = 1'b0;
            end
        end
        if (!got) chk("cpu_ack_timeout", 0, 1);
        cpu_req = 1'b0;
        if (trig_row >= 0) chk("fetch_reads_before_cpu", 32'(reads), WORDS);
        if (we) shadow[addr] = wd;
        last_rd = exp_rd;
        @(negedge clk);
        chk("cpu_ack_pulse", 32'(cpu_ack), 0);
        chk("cpu_rdata_hold", 32'(cpu_rdata), 32'(last_rd));
    endtask

    initial begin
        int r, nr;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        for (int x = 0; x < (1 << ADDR_W); x++) begin
            vram[x] = 16'($urandom);
            shadow[x] = vram[x];
        end
        last_rd = '0;
        ovr_exp = 1'b0;
        reset = 1'b1;
        for (int n = 0; n < 4; n++) begin
            pixel_row = 10'($urandom);
            pixel_column = (n == 1) ? 10'd640 : 10'($urandom);
            cpu_req = 1'($urandom);
            cpu_we = 1'($urandom);
            cpu_addr = 14'($urandom);
            cpu_wdata = 16'($urandom);
            overrun_clr = 1'($urandom);
            @(negedge clk);
            chk("rst_cpu_ack", 32'(cpu_ack), 0);
            chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
            chk("rst_mem_en", 32'(mem_en), 0);
            chk("rst_mem_we", 32'(mem_we), 0);
            chk("rst_mem_addr", 32'(mem_addr), 0);
            chk("rst_mem_wdata", 32'(mem_wdata), 0);
            chk("rst_lb_we", 32'(lb_we), 0);
            chk("rst_lb_addr", 32'(lb_addr), 0);
            chk("rst_lb_wdata", 32'(lb_wdata), 0);
            chk("rst_busy", 32'(fetch_busy), 0);
            chk("rst_overrun", 32'(overrun), 0);
        end
        pixel_row = 10'd0;
        pixel_column = 10'd0;
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        overrun_clr = 1'b0;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk_quiet("post_rst");
        end

        run_fetch(9, 0, 0, 0);
        run_fetch(524, 0, 0, 0);
        run_fetch(479, 0, 0, 0);

        cpu_access(1'b1, 14'h123, 16'hBEEF, -1);
        cpu_access(1'b0, 14'h123, 16'h0000, -1);
        cpu_access(1'b0, 14'h123, 16'h0000, 20);

        run_fetch(100, 5, 0, 0);
        run_fetch(200, 7, 7, 0);
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        ovr_exp = 1'b0;
        chk("overrun_cleared", 32'(overrun), 0);

        run_fetch(50, 0, 0, 13);
        repeat (4) begin
            @(negedge clk);
            chk_quiet("after_mid_rst");
        end
        chk("after_mid_rst_rdata", 32'(cpu_rdata), 0);

        for (int n = 0; n < 5; n++) begin
            r = int'($urandom_range(0, 478));
            nr = r + 1;
            a = ADDR_W'(FB_BASE + nr * STRIDE + int'($urandom_range(0, WORDS - 1)));
            d = 16'($urandom);
            cpu_access(1'b1, a, d, -1);
            run_fetch(r, 0, 0, 0);
            cpu_access(1'b0, a, 16'h0000, -1);
            cpu_access(1'b0, 14'($urandom), 16'h0000, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
